// File: rtl/reg_alu_pkg.sv
// Shared constants for the register-file/ALU pipeline: opcodes and default geometry.
package reg_alu_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultDepth = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ADC  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes the result and, for carry-producing ops, the new carry.
module alu_core
  import reg_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] d_in_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_next_o,
  output logic             c_update_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum         = '0;
    y_o         = '0;
    cout_next_o = 1'b0;
    c_update_o  = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        sum         = {1'b0, a_i} + {1'b0, b_i};
        y_o         = sum[WIDTH-1:0];
        cout_next_o = sum[WIDTH];
        c_update_o  = 1'b1;
      end
      OP_SUB: begin
        y_o         = a_i - b_i;
        cout_next_o = (a_i >= b_i);  // carry means "no borrow"
        c_update_o  = 1'b1;
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_ADC: begin
        sum         = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
        y_o         = sum[WIDTH-1:0];
        cout_next_o = sum[WIDTH];
        c_update_o  = 1'b1;
      end
      OP_SHL: begin
        y_o         = {a_i[WIDTH-2:0], 1'b0};
        cout_next_o = a_i[WIDTH-1];
        c_update_o  = 1'b1;
      end
      OP_PASS: y_o = d_in_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_alu_pipe.sv
// Register file feeding an ALU through a one-entry result stage with valid/ready
// handshakes, operand forwarding from that stage, and an architectural carry flag.
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [AW-1:0]    rd_addr_a_i,
  input  logic [AW-1:0]    rd_addr_b_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] d_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic             out_valid_q, st_we_q, c_q, cout_q, zero_q;
  logic [AW-1:0]    st_wa_q;
  logic [WIDTH-1:0] result_q;

  logic             accept, retire, st_wa_ok, fwd_ok;
  logic [WIDTH-1:0] op_a, op_b, alu_y;
  logic             alu_cout, alu_cupd, c_d;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign retire     = out_valid_q && out_ready_i;

  // Out-of-range destinations (non-power-of-two DEPTH) never write and never forward.
  assign st_wa_ok = (32'(st_wa_q) < DEPTH);
  assign fwd_ok   = out_valid_q && st_we_q && st_wa_ok;

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (32'(rd_addr_a_i) < DEPTH) op_a = rf_q[rd_addr_a_i];
    if (32'(rd_addr_b_i) < DEPTH) op_b = rf_q[rd_addr_b_i];
    if (fwd_ok && (st_wa_q == rd_addr_a_i)) op_a = result_q;
    if (fwd_ok && (st_wa_q == rd_addr_b_i)) op_b = result_q;
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i       (op_i),
    .a_i        (op_a),
    .b_i        (op_b),
    .d_in_i     (d_in_i),
    .cin_i      (c_q),
    .y_o        (alu_y),
    .cout_next_o(alu_cout),
    .c_update_o (alu_cupd)
  );

  assign c_d = alu_cupd ? alu_cout : c_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) rf_q[i] <= '0;
      out_valid_q <= 1'b0;
      st_we_q     <= 1'b0;
      st_wa_q     <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      if (retire && st_we_q && st_wa_ok) rf_q[st_wa_q] <= result_q;
      if (accept) begin
        out_valid_q <= 1'b1;
        st_we_q     <= wr_en_i;
        st_wa_q     <= wr_addr_i;
        result_q    <= alu_y;
        cout_q      <= c_d;
        zero_q      <= (alu_y == '0);
        c_q         <= c_d;
      end else if (retire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign cout_o      = cout_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Bench for reg_alu_pipe: directed scenarios plus randomized traffic against an ISA-level model.
module tb_reg_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, wr_en, out_valid, out_ready, cout, zero;
  logic [2:0]  op, rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in, result;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model: each accepted instruction sees all earlier ones.
  int mregs [8];
  bit mc;
  int exp_res;
  bit exp_cout, exp_zero, exp_valid, exp_rdy, dut_rdy;

  always #5 clk = ~clk;

  reg_alu_pipe #(
    .WIDTH(16),
    .DEPTH(8)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .rd_addr_a_i(rd_addr_a),
    .rd_addr_b_i(rd_addr_b),
    .wr_addr_i  (wr_addr),
    .wr_en_i    (wr_en),
    .d_in_i     (d_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .cout_o     (cout),
    .zero_o     (zero)
  );

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    mc = 0; exp_res = 0; exp_cout = 0; exp_zero = 0; exp_valid = 0;
  endfunction

  function automatic void model_exec(input int xop, input int ra, input int rb, input int wa,
                                     input bit we, input int imm);
    int a = mregs[ra];
    int b = mregs[rb];
    int r = 0;
    bit c = mc;
    case (xop)
      0: begin r = a + b; c = (r > 65535); r = r % 65536; end
      1: begin c = (a >= b); r = (a - b + 65536) % 65536; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a + b + int'(mc); c = (r > 65535); r = r % 65536; end
      6: begin c = (a >= 32768); r = (a * 2) % 65536; end
      default: r = imm;
    endcase
    mc = c; exp_res = r; exp_cout = c; exp_zero = (r == 0); exp_valid = 1;
    if (we) mregs[wa] = r;
  endfunction

  // One clock of stimulus; leaves the bench #1 after the rising edge.
  task automatic drive(input bit v, input int xop, input int ra, input int rb, input int wa,
                       input bit we, input int imm, input bit ordy);
    @(negedge clk);
    in_valid = v; op = 3'(xop); rd_addr_a = 3'(ra); rd_addr_b = 3'(rb);
    wr_addr = 3'(wa); wr_en = we; d_in = 16'(imm); out_ready = ordy;
    #1;
    dut_rdy = in_ready;
    exp_rdy = !exp_valid || ordy;
    @(posedge clk);
    #1;
    if (v && exp_rdy) model_exec(xop, ra, rb, wa, we, imm);
    else if (exp_valid && ordy) exp_valid = 0;
  endtask

  task automatic test_reset();
    drive(1, 7, 0, 0, 1, 1, 'h5555, 1);
    drive(1, 1, 1, 0, 2, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 reset = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 16'h0) begin n_err++; $display("FAIL rst_result: got %h want 0000", result); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", cout); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL rst_zero: got %b want 0", zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0; reset = 0;
    model_reset();
  endtask

  task automatic test_forwarding();
    drive(1, 7, 0, 0, 1, 1, 'h1234, 1);
    n_cmp++; if (result !== 16'h1234) begin n_err++; $display("FAIL fwd_pass1: got %h want 1234", result); end
    drive(1, 7, 0, 0, 2, 1, 'hFFFF, 1);
    drive(1, 0, 1, 2, 3, 1, 0, 1);
    n_cmp++; if (result !== 16'h1233) begin n_err++; $display("FAIL fwd_add: got %h want 1233", result); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL fwd_add_cout: got %b want 1", cout); end
  endtask

  task automatic test_carry_chain();
    drive(1, 5, 3, 0, 4, 1, 0, 1);
    n_cmp++; if (result !== 16'h1234) begin n_err++; $display("FAIL adc_result: got %h want 1234", result); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL adc_cout: got %b want 0", cout); end
    drive(1, 1, 1, 1, 5, 1, 0, 1);
    n_cmp++; if (result !== 16'h0) begin n_err++; $display("FAIL sub_result: got %h want 0000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL sub_zero: got %b want 1", zero); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub_cout: got %b want 1", cout); end
  endtask

  task automatic test_shift_logic();
    drive(1, 7, 0, 0, 6, 1, 'h8001, 1);
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL pass_keeps_c: got %b want 1", cout); end
    drive(1, 6, 6, 0, 6, 1, 0, 1);
    n_cmp++; if (result !== 16'h0002) begin n_err++; $display("FAIL shl_result: got %h want 0002", result); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL shl_cout: got %b want 1", cout); end
    drive(1, 4, 6, 6, 7, 1, 0, 1);
    n_cmp++; if (result !== 16'h0) begin n_err++; $display("FAIL xor_result: got %h want 0000", result); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL xor_cout: got %b want 1", cout); end
  endtask

  task automatic test_backpressure();
    drive(1, 7, 0, 0, 1, 1, 'h00AA, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 1, 1, 2, 1, 0, 0);
      n_cmp++; if (dut_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, dut_rdy); end
      n_cmp++; if (result !== 16'h00AA) begin n_err++; $display("FAIL bp_hold[%0d]: got %h want 00aa", i, result); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
    end
    // Accepted on the retire edge; carry from the earlier XOR is still 1.
    drive(1, 5, 1, 1, 2, 1, 0, 1);
    n_cmp++; if (result !== 16'h0155) begin n_err++; $display("FAIL bp_adc: got %h want 0155", result); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL bp_adc_cout: got %b want 0", cout); end
    drive(1, 0, 2, 0, 0, 0, 0, 1);
    n_cmp++; if (result !== 16'h0155) begin n_err++; $display("FAIL bp_fwd_r2: got %h want 0155", result); end
  endtask

  task automatic test_reset_mid_op();
    drive(1, 7, 0, 0, 7, 1, 'hBEEF, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (result !== 16'hBEEF) begin n_err++; $display("FAIL rmo_stall: got %h want beef", result); end
    @(posedge clk);
    #3 reset = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmo_valid: got %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 0; reset = 0;
    model_reset();
    drive(1, 0, 7, 0, 0, 0, 0, 1);
    n_cmp++; if (result !== 16'h0) begin n_err++; $display("FAIL rmo_r7: got %h want 0000", result); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL rmo_zero: got %b want 1", zero); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 5) != 0, int'($urandom % 8), int'($urandom % 8), int'($urandom % 8),
            int'($urandom % 8), $urandom_range(0, 1) == 1, int'($urandom % 65536),
            ($urandom % 10) < 7);
      n_cmp++; if (dut_rdy !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, dut_rdy, exp_rdy); end
      n_cmp++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++;
        if (result !== 16'(exp_res) || cout !== exp_cout || zero !== exp_zero) begin
          n_err++;
          $display("FAIL rnd_out[%0d]: got %h/c%b/z%b want %h/c%b/z%b", i, result, cout, zero,
                   16'(exp_res), exp_cout, exp_zero);
        end
      end
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; op = 0; rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0;
    wr_en = 0; d_in = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    test_reset();
    test_forwarding();
    test_carry_chain();
    test_shift_logic();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_alu_pipe.md
Name: reg_alu_pipe

Overview:
- Parametrised successor to the team's register-file + ALU datapath.
- DEPTH x WIDTH register file feeds a 3-bit-opcode ALU through a one-entry execute/result stage.
- Valid/ready handshakes on input and output; results retire to the register file only when consumed.
- Includes operand forwarding, an architectural carry flag (ADC support) and a zero flag.

Parameters:
- WIDTH, 16, datapath and register width (>= 2).
- DEPTH, 8, number of registers (>= 2; need not be a power of two).
- AW, derived localparam = clog2(DEPTH), register address width; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- op  in  3  opcode.
- rd_addr_a  in  AW  operand A register.
- rd_addr_b  in  AW  operand B register.
- wr_addr  in  AW  destination register.
- wr_en  in  1  write result back to wr_addr on retire.
- d_in  in  WIDTH  immediate for PASS.
- out_valid  out  1  result stage holds an entry.
- out_ready  in  1  consumer takes the result; the entry retires when out_valid && out_ready.
- result  out  WIDTH  registered ALU result.
- cout  out  1  registered carry of that result.
- zero  out  1  registered, high when result == 0.

Behaviour:
- Reset (async, active-high):
  - All registers, carry flag, result, cout and zero go to 0; out_valid goes to 0.
  - Any pending entry is discarded with no writeback.
- in_ready = !out_valid || out_ready. This is combinational, so a new accept and a retire can happen in the same cycle.
- Accept edge:
  - Operands are read, the ALU is evaluated, and the result, cout, zero, wr_addr and wr_en are captured into the result stage.
  - out_valid goes to 1 the next cycle. Latency is 1 cycle from accept to out_valid.
- Retire edge:
  - If wr_en, regfile[wr_addr] <= result.
  - If there is no simultaneous accept, out_valid goes to 0.
  - If there is a simultaneous accept, the new entry replaces the old one and out_valid stays 1.
- Forwarding: an operand read returns the stage result instead of the register file when out_valid && stage wr_en && stage wr_addr == read addr. Applies to A and B independently and to both stalled and retiring entries.
- Opcodes (carry = C flag):
  - 000 ADD: a+b; C = carry out.
  - 001 SUB: a-b; C = 1 when no borrow (a >= b unsigned).
  - 010 AND; 011 OR; 100 XOR: C unchanged.
  - 101 ADC: a+b+C; C = carry out.
  - 110 SHL: a<<1, LSB 0; C = a[WIDTH-1].
  - 111 PASS: d_in; C unchanged.
- The C flag updates at the accept edge, so a back-to-back ADC sees the previous instruction's carry.
- cout = C value after the instruction, i.e. the updated carry, or the carried-over value for ops that leave C unchanged.
- Arithmetic is modulo 2^WIDTH and unsigned.
- Addresses >= DEPTH (non-power-of-two DEPTH): reads return 0, writes are ignored, no forwarding match.
- Backpressure: while out_valid && !out_ready, result, cout and zero hold stable and in_ready = 0.
- in_valid while in_ready = 0: ignored. The instruction is not accepted, and C and the register file are untouched.
- Retire with wr_en = 0: result is consumed and the register file is unchanged.

Decomposition:
- Package reg_alu_pkg holds the opcode localparams (OP_ADD..OP_PASS) and the default WIDTH/DEPTH constants.
- One combinational sub-module, alu_core: inputs op, a, b, d_in, cin; outputs y, cout_next, c_update.
- Register file, forwarding mux, C flag and result stage live in reg_alu_pipe.

Test Plan (WIDTH=16, DEPTH=8):
- Reset: assert reset mid-cycle -> out_valid=0, result=0, cout=0, zero=0, in_ready=1 immediately, without waiting for a clock edge.
- Forwarding: out_ready=1; PASS 0x1234 ->r1, PASS 0xFFFF ->r2, ADD r1,r2 ->r3 on consecutive cycles -> third result 0x1233, cout=1; r2 is forwarded from the retiring stage.
- Carry chain: next, ADC r3,r0 ->r4 -> result 0x1234, cout=0. Then SUB r1,r1 ->r5 -> result 0, zero=1, cout=1.
- Shift and logic: PASS 0x8001 ->r6, then SHL r6 ->r6 -> 0x0002, cout=1. XOR r6,r6 -> 0, cout stays 1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stable, C unchanged, and no register write until out_ready=1. Then the stalled entry retires and the waiting instruction is accepted on the same edge, reading the forwarded value.
- Reset mid-op: a PASS 0xBEEF ->r7 entry is stalled; assert reset -> entry dropped, a later read of r7 returns 0.
